multi_ctrl: RTL and testbench
=============================

Name: multi_ctrl

Overview:
Main control unit for the multi-cycle MIPS core.
- Moore FSM sequences the shared datapath (PC, IR, single memory port, register file, ALU) through fetch / decode / execute / memory / writeback, one state per cycle.
- Decodes op/funct from IR and drives every datapath enable and mux select.
- Keeps retired-instruction and cycle counters for CPI measurement.

Parameters:
STATE_W, 4, width of state register
CNT_W, 32, width of perf counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
op  in  6  IR[31:26]; valid from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, current cycle
pc_en  out  1  PC write enable (final, branch condition included)
pc_src  out  2  00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target {PC[31:28],IR[25:0],2'b00}, 11 rs value
ir_wr  out  1  IR load
iord  out  1  memory address: 0 PC, 1 ALUOut
mem_wr  out  1  memory write
reg_wr  out  1  register file write
reg_dst  out  2  00 rt, 01 rd, 10 $31
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
alu_src_a  out  1  0 PC, 1 A register
alu_src_b  out  2  00 B, 01 const 4, 10 ext imm, 11 sext imm<<2
ext_op  out  2  00 sign, 01 zero, 10 upper (imm<<16)
alu_op  out  3  000 ADD, 001 SUB, 010 OR, 011 LUI, 100 use funct
instr_done  out  1  one-cycle pulse in final state of each instruction
halted  out  1  FSM in HALT
state  out  STATE_W  current state, for debug
instr_cnt  out  CNT_W  retired instructions
cycle_cnt  out  CNT_W  cycles since reset

Behaviour:
- Reset (synchronous, sampled on rising clk while reset=1):
  - state<=FETCH(0); both counters <=0.
  - All outputs take FETCH values in the cycle after reset deasserts.
  - Reset mid-instruction aborts it: no mem_wr or reg_wr in the reset cycle (reset overrides state decode; all enables are 0 while reset=1).
- Outputs are combinational from the state register. Exceptions:
  - pc_en in BRANCH depends on zero (Mealy path).
  - alu_op / ext_op in EXEC_I depend on op.
  - Any signal not listed for a state is 0.
- States, output values and transitions:
  - FETCH(0): ir_wr=1, pc_en=1, pc_src=00, alu_src_a=0, alu_src_b=01, alu_op=ADD -> DECODE.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=ADD (precompute branch target). Next state by op:
    - lw 100011 / sw 101011 -> MEMADR
    - R-type 000000 -> EXEC_R, or JUMP when funct=001000 (jr)
    - beq 000100 / bne 000101 -> BRANCH
    - addi 001000 / ori 001101 / lui 001111 -> EXEC_I
    - j 000010 / jal 000011 -> JUMP
    - any other op -> ILLEGAL handling (see Optional Feature)
  - MEMADR(2): alu_src_a=1, alu_src_b=10, ext_op=00, alu_op=ADD -> MEMRD (lw) or MEMWR (sw).
  - MEMRD(3): iord=1 -> MEMWB.
  - MEMWB(4): reg_wr=1, reg_dst=00, mem_to_reg=01, instr_done=1 -> FETCH.
  - MEMWR(5): iord=1, mem_wr=1, instr_done=1 -> FETCH.
  - EXEC_R(6): alu_src_a=1, alu_src_b=00, alu_op=100 -> RWB.
  - RWB(7): reg_wr=1, reg_dst=01, mem_to_reg=00, instr_done=1 -> FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01, pc_en=(op==beq)?zero:~zero, instr_done=1 -> FETCH.
  - EXEC_I(9): alu_src_a=1, alu_src_b=10. By op:
    - addi: ext_op=00, alu_op=ADD
    - ori: ext_op=01, alu_op=OR
    - lui: ext_op=10, alu_op=LUI
    - -> IWB
  - IWB(10): reg_wr=1, reg_dst=00, mem_to_reg=00, instr_done=1 -> FETCH.
  - JUMP(11): pc_en=1, instr_done=1 -> FETCH. By instruction:
    - j: pc_src=10
    - jal: pc_src=10, plus reg_wr=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4)
    - jr: pc_src=11
  - HALT(12): all enables 0, halted=1; held until reset.
  - Unused encodings 13-15 -> FETCH next cycle, outputs as HALT.
- Cycle counts per instruction:
  - lw: 5
  - sw, R-type, I-type ALU: 4
  - beq, bne, j, jal, jr: 3
- Counters:
  - cycle_cnt +1 every non-reset cycle, including HALT.
  - instr_cnt +1 on each instr_done.
  - Both wrap modulo 2^CNT_W.
  - Reset has priority over increment.

Optional Feature:
Macro: MULTI_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unrecognised op (or R-type with unsupported funct 001001..111111 except the ALU set) in DECODE -> HALT; halted=1; instr_cnt does not increment.
- Undefined: unrecognised op is a NOP. DECODE -> FETCH with instr_done=1 in DECODE (2-cycle NOP); halted is tied 0; HALT is unreachable.

Test Plan:
1. reset=1 for 2 cycles, then release -> state=0, ir_wr=1, pc_en=1, pc_src=00, alu_src_b=01, instr_cnt=0, cycle_cnt=1 after first active edge.
2. op=100011 (lw) -> states 0,1,2,3,4,0; reg_wr=1 only in state 4 with mem_to_reg=01; instr_done single pulse; instr_cnt=1 after 5 cycles.
3. op=000100 (beq): zero=1 in BRANCH -> pc_en=1, pc_src=01. Repeat with zero=0 -> pc_en=0. Repeat with op=000101 (bne), zero=0 -> pc_en=1. Each takes 3 cycles.
4. op=000011 (jal) -> JUMP asserts pc_en=1, pc_src=10, reg_wr=1, reg_dst=10, mem_to_reg=10. Then op=0/funct=001000 (jr) -> pc_src=11, reg_wr=0.
5. sw with reset asserted in MEMWR cycle -> mem_wr=0 that cycle, next state=FETCH, counters=0.
6. op=111111 -> with macro: state=12, halted=1, stays for 10 cycles, cycle_cnt keeps counting, instr_cnt unchanged. Without macro: returns to FETCH after 2 cycles, instr_cnt +1.

Source files
------------

// File: rtl/multi_ctrl.sv
// rtl/multi_ctrl.sv - multi-cycle MIPS main control FSM with perf counters; optional macro MULTI_CTRL_ILLEGAL_TRAP_EN
module multi_ctrl #(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pc_en,
  output logic [1:0]         pc_src,
  output logic               ir_wr,
  output logic               iord,
  output logic               mem_wr,
  output logic               reg_wr,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         ext_op,
  output logic [2:0]         alu_op,
  output logic               instr_done,
  output logic               halted,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   instr_cnt,
  output logic [CNT_W-1:0]   cycle_cnt
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_LUI   = 3'b011;
  localparam logic [2:0] ALU_FUNCT = 3'b100;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = STATE_W'(0),
    S_DECODE = STATE_W'(1),
    S_MEMADR = STATE_W'(2),
    S_MEMRD  = STATE_W'(3),
    S_MEMWB  = STATE_W'(4),
    S_MEMWR  = STATE_W'(5),
    S_EXEC_R = STATE_W'(6),
    S_RWB    = STATE_W'(7),
    S_BRANCH = STATE_W'(8),
    S_EXEC_I = STATE_W'(9),
    S_IWB    = STATE_W'(10),
    S_JUMP   = STATE_W'(11),
    S_HALT   = STATE_W'(12)
  } state_t;

  state_t state_q;
  logic   r_funct_ok;
  logic   decode_illegal;
  state_t illegal_next;

  assign state = state_q;

`ifdef MULTI_CTRL_ILLEGAL_TRAP_EN
  assign illegal_next = S_HALT;
`else
  assign illegal_next = S_FETCH;
`endif

  // classify the IR opcode/funct as supported or not
  always_comb begin
`ifdef MULTI_CTRL_ILLEGAL_TRAP_EN
    // shifts/jr (funct up to 001000) plus the add..nor and slt/sltu ALU group
    r_funct_ok = (funct <= 6'b001000) || (funct[5:3] == 3'b100) ||
                 (funct == 6'b101010) || (funct == 6'b101011);
`else
    r_funct_ok = 1'b1;
`endif
    case (op)
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LUI, OP_J, OP_JAL:
        decode_illegal = 1'b0;
      OP_R:
        decode_illegal = !r_funct_ok;
      default:
        decode_illegal = 1'b1;
    endcase
  end

  // state sequencing and performance counters; reset wins over counting
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (instr_done)
        instr_cnt <= instr_cnt + CNT_W'(1);
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          if (decode_illegal) begin
            state_q <= illegal_next;
          end else begin
            case (op)
              OP_LW, OP_SW:             state_q <= S_MEMADR;
              OP_R:                     state_q <= (funct == FN_JR) ? S_JUMP : S_EXEC_R;
              OP_BEQ, OP_BNE:           state_q <= S_BRANCH;
              OP_ADDI, OP_ORI, OP_LUI:  state_q <= S_EXEC_I;
              default:                  state_q <= S_JUMP;
            endcase
          end
        end
        S_MEMADR: state_q <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state_q <= S_MEMWB;
        S_EXEC_R: state_q <= S_RWB;
        S_EXEC_I: state_q <= S_IWB;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // datapath controls decoded from the state; reset forces every control low
  always_comb begin
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    ir_wr      = 1'b0;
    iord       = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_op     = 2'b00;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    halted     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          ir_wr     = 1'b1;
          pc_en     = 1'b1;
          alu_src_b = 2'b01;
        end
        S_DECODE: begin
          // branch target precomputed here while the opcode is decoded
          alu_src_b = 2'b11;
`ifndef MULTI_CTRL_ILLEGAL_TRAP_EN
          instr_done = decode_illegal;
`endif
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: iord = 1'b1;
        S_MEMWB: begin
          reg_wr     = 1'b1;
          mem_to_reg = 2'b01;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          iord       = 1'b1;
          mem_wr     = 1'b1;
          instr_done = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_RWB: begin
          reg_wr     = 1'b1;
          reg_dst    = 2'b01;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_src     = 2'b01;
          pc_en      = (op == OP_BEQ) ? zero : ~zero;
          instr_done = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          case (op)
            OP_ORI: begin
              ext_op = 2'b01;
              alu_op = ALU_OR;
            end
            OP_LUI: begin
              ext_op = 2'b10;
              alu_op = ALU_LUI;
            end
            default: begin
              ext_op = 2'b00;
              alu_op = ALU_ADD;
            end
          endcase
        end
        S_IWB: begin
          reg_wr     = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_en      = 1'b1;
          instr_done = 1'b1;
          if (op == OP_R) begin
            pc_src = 2'b11;
          end else begin
            pc_src = 2'b10;
            if (op == OP_JAL) begin
              // link: PC already holds PC+4 from FETCH
              reg_wr     = 1'b1;
              reg_dst    = 2'b10;
              mem_to_reg = 2'b10;
            end
          end
        end
        default: begin
`ifdef MULTI_CTRL_ILLEGAL_TRAP_EN
          halted = 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_ctrl.sv
// tb/tb_multi_ctrl.sv - table-driven scoreboard bench for multi_ctrl
module tb_multi_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  op = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        zero = 1'b0;
  logic        pc_en, ir_wr, iord, mem_wr, reg_wr, alu_src_a, instr_done, halted;
  logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src_b, ext_op;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] instr_cnt, cycle_cnt;

  multi_ctrl #(.STATE_W(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pc_en(pc_en), .pc_src(pc_src), .ir_wr(ir_wr), .iord(iord),
    .mem_wr(mem_wr), .reg_wr(reg_wr), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_op(ext_op), .alu_op(alu_op), .instr_done(instr_done),
    .halted(halted), .state(state), .instr_cnt(instr_cnt),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int unsigned mcyc = 0;
  int unsigned exp_icnt = 0;

  // reference cycle counter
  always @(posedge clk) mcyc <= reset ? 0 : mcyc + 1;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         ncyc;
    logic [3:0] fstate;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] mtr;
    logic       mem_wr;
    logic [1:0] iext;
    logic [2:0] ialu;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z, input int n,
                     input logic [3:0] fs, input logic pe, input logic [1:0] ps,
                     input logic rw, input logic [1:0] rd, input logic [1:0] mt,
                     input logic mw, input logic [1:0] ie, input logic [2:0] ia);
    vec_t v;
    v.op = o; v.funct = f; v.zero = z; v.ncyc = n; v.fstate = fs;
    v.pc_en = pe; v.pc_src = ps; v.reg_wr = rw; v.reg_dst = rd; v.mtr = mt;
    v.mem_wr = mw; v.iext = ie; v.ialu = ia;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t e;
    int   cyc;
    bit   done;

    //   op         funct      z  n  fst pe ps rw rd mt mw iext ialu
    add(6'b100011, 6'b000000, 0, 5, 4,  0, 0, 1, 0, 1, 0, 0, 0); // lw
    add(6'b101011, 6'b000000, 0, 4, 5,  0, 0, 0, 0, 0, 1, 0, 0); // sw
    add(6'b000000, 6'b100000, 0, 4, 7,  0, 0, 1, 1, 0, 0, 0, 0); // add
    add(6'b001000, 6'b000000, 0, 4, 10, 0, 0, 1, 0, 0, 0, 0, 0); // addi
    add(6'b001101, 6'b000000, 0, 4, 10, 0, 0, 1, 0, 0, 0, 1, 2); // ori
    add(6'b001111, 6'b000000, 0, 4, 10, 0, 0, 1, 0, 0, 0, 2, 3); // lui
    add(6'b000100, 6'b000000, 1, 3, 8,  1, 1, 0, 0, 0, 0, 0, 0); // beq taken
    add(6'b000100, 6'b000000, 0, 3, 8,  0, 1, 0, 0, 0, 0, 0, 0); // beq not taken
    add(6'b000101, 6'b000000, 0, 3, 8,  1, 1, 0, 0, 0, 0, 0, 0); // bne taken
    add(6'b000101, 6'b000000, 1, 3, 8,  0, 1, 0, 0, 0, 0, 0, 0); // bne not taken
    add(6'b000010, 6'b000000, 0, 3, 11, 1, 2, 0, 0, 0, 0, 0, 0); // j
    add(6'b000011, 6'b000000, 0, 3, 11, 1, 2, 1, 2, 2, 0, 0, 0); // jal
    add(6'b000000, 6'b001000, 0, 3, 11, 1, 3, 0, 0, 0, 0, 0, 0); // jr
`ifndef MULTI_CTRL_ILLEGAL_TRAP_EN
    add(6'b111111, 6'b000000, 0, 2, 1,  0, 0, 0, 0, 0, 0, 0, 0); // illegal -> NOP
`endif

    // reset held two cycles; controls forced low meanwhile
    reset = 1'b1;
    op = 6'b100011;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir_wr", ir_wr, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_state", state, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    reset = 1'b0;
    #1;
    chk("fetch_state", state, 0);
    chk("fetch_ir_wr", ir_wr, 1);
    chk("fetch_pc_en", pc_en, 1);
    chk("fetch_pc_src", pc_src, 0);
    chk("fetch_alu_src_b", alu_src_b, 1);
    chk("fetch_instr_cnt", instr_cnt, 0);

    // lw state walk
    for (int k = 0; k < 5; k++) begin
      chk("lw_trace_state", state, k);
      chk("lw_trace_done", instr_done, (k == 4));
      chk("lw_trace_reg_wr", reg_wr, (k == 4));
      if (k == 4) chk("lw_mem_to_reg", mem_to_reg, 1);
      @(posedge clk);
      #1;
      if (k == 0) chk("first_edge_cycle_cnt", cycle_cnt, 1);
    end
    exp_icnt = 1;
    chk("lw_trace_end_state", state, 0);
    chk("lw_trace_instr_cnt", instr_cnt, exp_icnt);

    // table-driven instructions, expectations retired through the scoreboard
    foreach (tbl[i]) begin
      op = tbl[i].op;
      funct = tbl[i].funct;
      zero = tbl[i].zero;
      sb.push_back(tbl[i]);
      exp_icnt++;
      cyc = 0;
      done = 1'b0;
      while (!done && cyc < 10) begin
        cyc++;
        if (state == 4'd9) begin
          chk($sformatf("v%0d_ext_op", i), ext_op, tbl[i].iext);
          chk($sformatf("v%0d_alu_op", i), alu_op, tbl[i].ialu);
        end
        if (instr_done) begin
          done = 1'b1;
          e = sb.pop_front();
          chk($sformatf("v%0d_cycles", i), cyc, e.ncyc);
          chk($sformatf("v%0d_state", i), state, e.fstate);
          chk($sformatf("v%0d_pc_en", i), pc_en, e.pc_en);
          chk($sformatf("v%0d_pc_src", i), pc_src, e.pc_src);
          chk($sformatf("v%0d_reg_wr", i), reg_wr, e.reg_wr);
          chk($sformatf("v%0d_reg_dst", i), reg_dst, e.reg_dst);
          chk($sformatf("v%0d_mem_to_reg", i), mem_to_reg, e.mtr);
          chk($sformatf("v%0d_mem_wr", i), mem_wr, e.mem_wr);
        end else begin
          chk($sformatf("v%0d_early_write", i), {reg_wr, mem_wr}, 0);
        end
        @(posedge clk);
        #1;
      end
      if (!done) chk($sformatf("v%0d_timeout", i), 0, 1);
      chk($sformatf("v%0d_instr_cnt", i), instr_cnt, exp_icnt);
      chk($sformatf("v%0d_cycle_cnt", i), cycle_cnt, mcyc);
      chk($sformatf("v%0d_back_to_fetch", i), state, 0);
    end
    chk("sb_empty", sb.size(), 0);

`ifdef MULTI_CTRL_ILLEGAL_TRAP_EN
    // illegal op traps to HALT and stays there, counting cycles only
    op = 6'b111111;
    repeat (2) @(posedge clk);
    #1;
    chk("halt_state", state, 12);
    chk("halt_flag", halted, 1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("halt_hold", state, 12);
    end
    chk("halt_instr_cnt", instr_cnt, exp_icnt);
    chk("halt_cycle_cnt", cycle_cnt, mcyc);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_icnt = 0;
    #1;
    chk("halt_cleared", halted, 0);
`else
    chk("halted_tied_low", halted, 0);
`endif

    // reset landing on the sw write cycle suppresses the write
    op = 6'b101011;
    repeat (3) @(posedge clk);
    #1;
    chk("sw_in_memwr", state, 5);
    chk("sw_mem_wr_pre", mem_wr, 1);
    reset = 1'b1;
    #1;
    chk("sw_rst_mem_wr", mem_wr, 0);
    chk("sw_rst_done", instr_done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("sw_rst_state", state, 0);
    chk("sw_rst_instr_cnt", instr_cnt, 0);
    chk("sw_rst_cycle_cnt", cycle_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
